// File: rtl/operand_fetch.sv
// Operand-fetch stage: register file (2 read / 1 write), operand-B mux and one output slot.
// Optional OPFETCH_R0_ZERO_EN: register 0 is hardwired to zero.
module operand_fetch #(
  parameter int W   = 8,
  parameter int Ops = 4,
  parameter int RA  = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [Ops-1:0] in_op,
  input  logic [RA-1:0]  in_ra,
  input  logic [RA-1:0]  in_rb,
  input  logic [RA-1:0]  in_rd,
  input  logic [W-1:0]   in_imm,
  input  logic           in_use_imm,
  input  logic           wr_en,
  input  logic [RA-1:0]  wr_addr,
  input  logic [W-1:0]   wr_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_a,
  output logic [W-1:0]   out_b,
  output logic [Ops-1:0] out_op,
  output logic [RA-1:0]  out_rd,
  output logic [15:0]    issue_count
);

  localparam int NREG = 2 ** RA;

  logic [W-1:0]    regs_reg [NREG];
  logic [NREG-1:0] wr_hit;
  logic            wr_ok;
  logic [RA-1:0]   held_ra_reg;
  logic [RA-1:0]   held_rb_reg;
  logic            held_imm_reg;
  logic [W-1:0]    rd_a, rd_b;
  logic [W-1:0]    cap_a, cap_b;
  logic            accept, drain, stall;
  logic            byp_a, byp_b, ref_a, ref_b;

`ifdef OPFETCH_R0_ZERO_EN
  // Writes to register 0 are dropped, so it also never bypasses or refreshes.
  assign wr_ok = wr_en && (wr_addr != '0);
`else
  assign wr_ok = wr_en;
`endif

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_wr_dec
      assign wr_hit[gi] = wr_ok && (wr_addr == RA'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_hit[i]) regs_reg[i] <= wr_data;
      end
    end
  end

`ifdef OPFETCH_R0_ZERO_EN
  assign rd_a = (in_ra == '0) ? '0 : regs_reg[in_ra];
  assign rd_b = (in_rb == '0) ? '0 : regs_reg[in_rb];
`else
  assign rd_a = regs_reg[in_ra];
  assign rd_b = regs_reg[in_rb];
`endif

  // Handshake: ready depends only on the slot state, never on in_valid.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;
  assign stall    = out_valid && !out_ready;

  // Same-cycle writeback is forwarded into the captured operands.
  assign byp_a = wr_ok && (wr_addr == in_ra);
  assign byp_b = wr_ok && (wr_addr == in_rb);
  assign cap_a = byp_a ? wr_data : rd_a;
  assign cap_b = in_use_imm ? in_imm : (byp_b ? wr_data : rd_b);

  // A held slot tracks writebacks to its sources so it never issues stale data.
  assign ref_a = stall && wr_ok && (wr_addr == held_ra_reg);
  assign ref_b = stall && wr_ok && (wr_addr == held_rb_reg) && !held_imm_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_a        <= '0;
      out_b        <= '0;
      out_op       <= '0;
      out_rd       <= '0;
      held_ra_reg  <= '0;
      held_rb_reg  <= '0;
      held_imm_reg <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_a        <= cap_a;
      out_b        <= cap_b;
      out_op       <= in_op;
      out_rd       <= in_rd;
      held_ra_reg  <= in_ra;
      held_rb_reg  <= in_rb;
      held_imm_reg <= in_use_imm;
    end else begin
      if (drain) out_valid <= 1'b0;
      if (ref_a) out_a <= wr_data;
      if (ref_b) out_b <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_count <= '0;
    end else if (drain) begin
      issue_count <= issue_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed scoreboard bench for operand_fetch; expected slots are queued at issue time.
module tb_operand_fetch;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [2:0] rd;
  } txn_t;

`ifdef OPFETCH_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_use_imm;
  logic [3:0] in_op;
  logic [2:0] in_ra, in_rb, in_rd;
  logic [7:0] in_imm;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       out_valid, out_ready;
  logic [7:0] out_a, out_b;
  logic [3:0] out_op;
  logic [2:0] out_rd;
  logic [15:0] issue_count;

  txn_t exp_q[$];
  int checks = 0;
  int fails  = 0;
  int ntxn   = 0;

  operand_fetch #(.W(8), .Ops(4), .RA(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd),
    .in_imm(in_imm), .in_use_imm(in_use_imm),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_rd(out_rd),
    .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb,
                       input logic [2:0] rd, input logic [7:0] imm, input logic use_imm);
    in_valid   = 1'b1;
    in_op      = op;
    in_ra      = ra;
    in_rb      = rb;
    in_rd      = rd;
    in_imm     = imm;
    in_use_imm = use_imm;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] op, input logic [2:0] rd);
    txn_t t;
    t.a = a; t.b = b; t.op = op; t.rd = rd;
    exp_q.push_back(t);
  endtask

  task automatic write(input logic [2:0] addr, input logic [7:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
  endtask

  // Monitor: every downstream handshake pops one expected slot.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      txn_t act, exp;
      act = {out_a, out_b, out_op, out_rd};
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL txn_unexpected: got a=%h b=%h op=%h rd=%h, expected no slot",
                 out_a, out_b, out_op, out_rd);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          fails++;
          $display("FAIL txn %0d: got a=%h b=%h op=%h rd=%h, expected a=%h b=%h op=%h rd=%h",
                   ntxn, act.a, act.b, act.op, act.rd, exp.a, exp.b, exp.op, exp.rd);
        end else begin
          $display("txn %0d: a=%h b=%h op=%h rd=%h ok", ntxn, act.a, act.b, act.op, act.rd);
        end
      end
      ntxn++;
    end
  end

  initial begin
    int waited;
    rst_n = 1'b0;
    in_valid = 0; in_op = 0; in_ra = 0; in_rb = 0; in_rd = 0; in_imm = 0; in_use_imm = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_a", 32'(out_a), 0);
    check("rst_issue_count", 32'(issue_count), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;

    // Basic register read
    write(3'd1, 8'h12); tick();
    write(3'd2, 8'h34); tick();
    wr_en = 0;
    drive(4'd4, 3'd1, 3'd2, 3'd3, 8'h00, 1'b0); push(8'h12, 8'h34, 4'd4, 3'd3);
    tick();
    in_valid = 0;
    check("t1_out_valid", 32'(out_valid), 1);
    check("t1_out_a", 32'(out_a), 32'h12);
    tick();
    check("t1_drained", 32'(out_valid), 0);

    // Write-to-read bypass on both ports, then immediate select
    write(3'd5, 8'hAA);
    drive(4'd1, 3'd5, 3'd5, 3'd6, 8'h00, 1'b0); push(8'hAA, 8'hAA, 4'd1, 3'd6);
    tick();
    wr_en = 0;
    drive(4'd2, 3'd5, 3'd3, 3'd7, 8'h07, 1'b1); push(8'hAA, 8'h07, 4'd2, 3'd7);
    tick();
    in_valid = 0;
    tick();
    check("t2_issue_count", 32'(issue_count), 3);

    // Stall, back-pressure and stall refresh of A
    out_ready = 0;
    drive(4'd3, 3'd1, 3'd2, 3'd4, 8'h00, 1'b0); push(8'h55, 8'h34, 4'd3, 3'd4);
    tick();
    drive(4'd5, 3'd2, 3'd2, 3'd1, 8'h00, 1'b0);
    check("t3_in_ready_stall", 32'(in_ready), 0);
    tick();
    check("t3_hold_a", 32'(out_a), 32'h12);
    check("t3_hold_b", 32'(out_b), 32'h34);
    check("t3_hold_op", 32'(out_op), 3);
    write(3'd1, 8'h55);
    tick();
    wr_en = 0;
    check("t3_refresh_a", 32'(out_a), 32'h55);
    check("t3_b_kept", 32'(out_b), 32'h34);
    in_valid = 0;
    out_ready = 1;
    tick();
    check("t3_issue_count", 32'(issue_count), 4);
    check("t3_drained", 32'(out_valid), 0);

    // Back-to-back issue without bubbles; regs 0..3 = 00,55,34,00
    for (int i = 0; i < 4; i++) begin
      logic [7:0] ea;
      ea = (i == 1) ? 8'h55 : ((i == 2) ? 8'h34 : 8'h00);
      drive(4'(8 + i), 3'(i), 3'd0, 3'(i), 8'(8'h10 + i), 1'b1);
      push(ea, 8'(8'h10 + i), 4'(8 + i), 3'(i));
      check("t4_in_ready", 32'(in_ready), 1);
      tick();
      check("t4_out_valid", 32'(out_valid), 1);
    end
    in_valid = 0;
    tick();
    check("t4_issue_count", 32'(issue_count), 8);

    // Asynchronous reset in the middle of a stall
    out_ready = 0;
    drive(4'd6, 3'd2, 3'd5, 3'd1, 8'h00, 1'b0);
    tick();
    in_valid = 0;
    check("t5_stalled_valid", 32'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_valid", 32'(out_valid), 0);
    check("t5_async_count", 32'(issue_count), 0);
    check("t5_async_a", 32'(out_a), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1;
    drive(4'd7, 3'd1, 3'd5, 3'd2, 8'h00, 1'b0); push(8'h00, 8'h00, 4'd7, 3'd2);
    tick();
    in_valid = 0;
    tick();
    check("t5_issue_count", 32'(issue_count), 1);

    // Register 0 behaviour, plain read and same-cycle bypass
    write(3'd0, 8'hFF); tick();
    wr_en = 0;
    drive(4'd1, 3'd0, 3'd0, 3'd0, 8'h3C, 1'b1);
    push(R0Z ? 8'h00 : 8'hFF, 8'h3C, 4'd1, 3'd0);
    tick();
    write(3'd0, 8'hEE);
    drive(4'd2, 3'd1, 3'd0, 3'd5, 8'h00, 1'b0);
    push(8'h00, R0Z ? 8'h00 : 8'hEE, 4'd2, 3'd5);
    tick();
    wr_en = 0;
    in_valid = 0;
    tick();

    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      tick();
      waited++;
    end
    check("queue_empty", 32'(exp_q.size()), 0);
    check("final_issue_count", 32'(issue_count), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Operand-fetch stage sitting directly upstream of the combinational ALU.
- Holds the architectural register file: 2**RA registers, two read ports and one write port.
- Selects register or immediate for operand B, then registers the operands, ALU opcode and destination into one pipeline slot.
- Consumes decoded instructions through a valid/ready handshake; accepts writeback from the stage after the ALU.

Parameters:
- W, 8, data/register width (matches ALU W)
- Ops, 4, opcode width (matches ALU Ops)
- RA, 3, register address width; register count = 2**RA

Ports:
- Clk  input  1  clock, rising edge
- Reset  input  1  asynchronous, active-low reset
- InValid  input  1  decoder presents an instruction
- InReady  output  1  stage can accept this cycle
- InOp  input  Ops  ALU opcode
- InRa  input  RA  source register A
- InRb  input  RA  source register B
- InRd  input  RA  destination register, passed through
- InImm  input  W  immediate value
- InUseImm  input  1  1 = operand B is InImm, not reg[InRb]
- WrEn  input  1  writeback enable
- WrAddr  input  RA  writeback register
- WrData  input  W  writeback data
- OutValid  output  1  operand slot holds a valid instruction
- OutReady  input  1  downstream (ALU/execute) accepts the slot
- OutA  output  W  operand A, feeds ALU InputA
- OutB  output  W  operand B, feeds ALU InputB
- OutOp  output  Ops  feeds ALU Inst
- OutRd  output  RA  destination register
- IssueCount  output  16  count of slots accepted downstream

Behaviour:
- Reset (Reset=0, asynchronous): all registers, OutA, OutB, OutOp, OutRd and IssueCount = 0; OutValid = 0.
- InReady = !OutValid || OutReady (combinational). No combinational path from InValid to InReady.
- Accept: InValid && InReady at a rising edge. Next cycle OutValid = 1 and Out* hold the captured values. Latency is 1 cycle.
- Drain: OutValid && OutReady && !accept. Next cycle OutValid = 0; Out* keep their last values.
- Simultaneous drain and accept: OutValid stays 1 and the slot is loaded with the new instruction. This sustains 1 instruction per cycle.
- IssueCount increments by 1 on every OutValid && OutReady edge and wraps from 0xFFFF to 0.
- Register write: when WrEn=1, reg[WrAddr] = WrData at the edge. Writes happen independently of stall or handshake state.
- Write-to-read bypass: at accept, if WrEn && WrAddr==InRa, OutA captures WrData; same rule for InRb when InUseImm=0.
  - Captured A = bypass ? WrData : reg[InRa].
  - Captured B = InUseImm ? InImm : (bypass ? WrData : reg[InRb]).
- Stall refresh: while OutValid && !OutReady, a write whose WrAddr matches the held Ra updates OutA with WrData at that edge. Held Rb is refreshed the same way unless the slot uses the immediate. The stage keeps internal copies of Ra, Rb and UseImm for this.
- OutA/OutB hold their value while stalled, apart from stall refresh.
- Ra==Rb with a matching write: both operands are bypassed/refreshed.
- Reset asserted mid-stall: the slot is discarded and the register file is cleared.
- No arithmetic is performed; all widths pass through unchanged.

Optional Feature:
- Macro: OPFETCH_R0_ZERO_EN.
- Defined:
  - Register 0 always reads 0; writes to address 0 are ignored.
  - Bypass and stall refresh never apply to address 0.
- Undefined: register 0 is an ordinary register.

Test Plan:
- Reset, then WrEn writes reg1=0x12, reg2=0x34; accept Op=4 Ra=1 Rb=2 Rd=3 -> next cycle OutValid=1, OutA=0x12, OutB=0x34, OutOp=4, OutRd=3.
- Same cycle: WrEn reg5=0xAA and accept Ra=5 Rb=5 -> OutA=0xAA, OutB=0xAA. Also accept Ra=5 InUseImm=1 InImm=0x07 -> OutB=0x07.
- OutReady=0 with slot held (Ra=1) and InValid=1 -> InReady=0, Out* stable. Write reg1=0x55 during the stall -> OutA becomes 0x55 the next cycle. Raise OutReady -> IssueCount +1.
- Back-to-back: 4 instructions with InValid and OutReady held at 1 -> one issue per cycle, IssueCount=4, no bubbles.
- Reset pulsed low mid-stall -> OutValid=0 immediately (asynchronous), all registers read 0 afterwards, IssueCount=0.
- With OPFETCH_R0_ZERO_EN: write reg0=0xFF, accept Ra=0 -> OutA=0x00. Without the macro -> OutA=0xFF.
